// File: rtl/uart_rx.sv
// UART receiver: oversampled serial input, majority-vote bit sampling,
// optional even/odd parity, registered valid/error pulses.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rx_in,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    input  logic [5:0]            i_prescale,
    output logic [DATA_WIDTH-1:0] o_p_data,
    output logic                  o_data_valid,
    output logic                  o_par_err,
    output logic                  o_stp_err
);

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic [5:0]            edge_cnt_q, edge_cnt_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic [1:0]            samp_q, samp_d;
    logic                  bit_q, bit_d;
    logic [5:0]            prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_fail_q, par_fail_d;
    logic                  valid_q, valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic [5:0] half;
    logic       bit_end;
    logic       majority;
    logic       exp_par;

    always_comb begin
        half     = prescale_q >> 1;
        bit_end  = (edge_cnt_q == prescale_q - 6'd1);
        majority = (samp_q[0] & samp_q[1]) | (samp_q[0] & i_rx_in) | (samp_q[1] & i_rx_in);
        exp_par  = (^data_q) ^ par_typ_q;

        state_d    = state_q;
        edge_cnt_d = bit_end ? 6'd0 : edge_cnt_q + 6'd1;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        p_data_d   = p_data_q;
        samp_d     = samp_q;
        bit_d      = bit_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_fail_d = par_fail_q;
        valid_d    = 1'b0;
        par_err_d  = 1'b0;
        stp_err_d  = 1'b0;

        // Three mid-bit samples; the vote is resolved on the third one.
        if (edge_cnt_q == half - 6'd1) samp_d[0] = i_rx_in;
        if (edge_cnt_q == half)        samp_d[1] = i_rx_in;
        if (edge_cnt_q == half + 6'd1) bit_d = majority;

        unique case (state_q)
            StIdle: begin
                edge_cnt_d = 6'd0;
                bit_cnt_d  = '0;
                if (!i_rx_in) begin
                    // This cycle is edge count 0 of the start bit.
                    state_d    = StStart;
                    edge_cnt_d = 6'd1;
                    prescale_d = i_prescale;
                    par_en_d   = i_par_en;
                    par_typ_d  = i_par_typ;
                    par_fail_d = 1'b0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = bit_q ? StIdle : StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    data_d[bit_cnt_q] = bit_q;
                    if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    if (bit_q != exp_par) begin
                        par_err_d  = 1'b1;
                        par_fail_d = 1'b1;
                    end
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    stp_err_d = ~bit_q;
                    if (bit_q && !par_fail_q) begin
                        p_data_d = data_q;
                        valid_d  = 1'b1;
                    end
                    if (!i_rx_in) begin
                        state_d    = StStart;
                        edge_cnt_d = 6'd1;
                        prescale_d = i_prescale;
                        par_en_d   = i_par_en;
                        par_typ_d  = i_par_typ;
                        par_fail_d = 1'b0;
                    end else begin
                        state_d    = StIdle;
                        edge_cnt_d = 6'd0;
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                edge_cnt_d = 6'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            edge_cnt_q <= 6'd0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            p_data_q   <= '0;
            samp_q     <= 2'b11;
            bit_q      <= 1'b1;
            prescale_q <= 6'd0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_fail_q <= 1'b0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            p_data_q   <= p_data_d;
            samp_q     <= samp_d;
            bit_q      <= bit_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_fail_q <= par_fail_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            stp_err_q  <= stp_err_d;
        end
    end

    assign o_p_data     = p_data_q;
    assign o_data_valid = valid_q;
    assign o_par_err    = par_err_q;
    assign o_stp_err    = stp_err_q;

endmodule
